// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the shift units on the datapath.
//   - state_e        : iteration FSM states of shifter_iterative
//   - DEFAULT_WIDTH  : default operand/result width
//   - DEFAULT_SHAMT_W: default shift-amount width (= iteration count)
//   - CTL0_LOGICAL / CTL1_RIGHT : control encodings shared with the
//                      combinational ALU shifter
// ---------------------------------------------------------------------------
package shifter_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = $clog2(DEFAULT_WIDTH);

    // ctl0: 1 = logical, 0 = arithmetic
    localparam logic CTL0_LOGICAL = 1'b1;
    // ctl1: 1 = right shift, 0 = left shift
    localparam logic CTL1_RIGHT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : shifter_pkg

// File: rtl/bit_reverse.sv
// ---------------------------------------------------------------------------
// bit_reverse
// Purely combinational bit-order reversal: out[i] = in[WIDTH-1-i].
// Ports:
//   in_bits  - input vector
//   out_bits - bit-reversed copy of in_bits
// ---------------------------------------------------------------------------
module bit_reverse #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_bits,
    output logic [WIDTH-1:0] out_bits
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign out_bits[i] = in_bits[WIDTH-1-i];
    end

endmodule : bit_reverse

// File: rtl/shifter_iterative.sv
// ---------------------------------------------------------------------------
// shifter_iterative
// Multi-cycle, handshaked shift unit. One request is accepted in IDLE, then
// SHAMT_W cycles apply one power-of-two right-shift stage each, and the
// result is held in DONE until the consumer takes it. Left shifts are done
// by reversing the operand on the way in and the result on the way out, so
// the datapath only ever shifts right. Left shifts always zero-fill.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - request handshake
//   a                   - operand
//   b                   - shift amount (only b[SHAMT_W-1:0] used)
//   ctl0                - 1 = logical, 0 = arithmetic
//   ctl1                - 1 = right,   0 = left
//   out_valid/out_ready - result handshake
//   out_data            - shifted result
// ---------------------------------------------------------------------------
module shifter_iterative
    import shifter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctl0,
    input  logic             ctl1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               ctl1_q,  ctl1_d;
    logic               fill_q,  fill_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [WIDTH-1:0]   a_rev;
    logic [WIDTH-1:0]   data_rev;
    logic [SHAMT_W-1:0] stage_step;
    logic [2*WIDTH-1:0] stage_ext;
    logic [2*WIDTH-1:0] stage_ext_shr;
    logic [WIDTH-1:0]   stage_data;

    // Upper shift-amount bits are deliberately ignored.
    logic unused_b_upper;
    assign unused_b_upper = ^b[WIDTH-1:SHAMT_W];

    bit_reverse #(.WIDTH(WIDTH)) u_in_flip (
        .in_bits  (a),
        .out_bits (a_rev)
    );

    bit_reverse #(.WIDTH(WIDTH)) u_out_flip (
        .in_bits  (data_q),
        .out_bits (data_rev)
    );

    // Stage k shifts by 2^k: prepend a word of fill bits and take the low
    // WIDTH bits after the shift, so vacated MSBs receive the fill bit.
    assign stage_step    = SHAMT_W'(1) << cnt_q;
    assign stage_ext     = {{WIDTH{fill_q}}, data_q};
    assign stage_ext_shr = stage_ext >> stage_step;
    assign stage_data    = stage_ext_shr[WIDTH-1:0];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = (ctl1_q == CTL1_RIGHT) ? data_q : data_rev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            ctl1_q  <= 1'b0;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            ctl1_q  <= ctl1_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        ctl1_d  = ctl1_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = (ctl1 == CTL1_RIGHT) ? a : a_rev;
                    shamt_d = b[SHAMT_W-1:0];
                    ctl1_d  = ctl1;
                    // The fill bit fully captures ctl0: only an arithmetic
                    // right shift replicates the sign, everything else
                    // zero-fills, so ctl0 needs no register of its own.
                    fill_d  = ((ctl0 == CTL0_LOGICAL) || (ctl1 != CTL1_RIGHT))
                              ? 1'b0 : a[WIDTH-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shamt_q[cnt_q]) begin
                    data_d = stage_data;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SHAMT_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : shifter_iterative

// File: tb/tb_shifter_iterative.sv
// ---------------------------------------------------------------------------
// tb_shifter_iterative
// Self-checking bench for shifter_iterative: a table of directed vectors,
// hand-written backpressure and mid-operation reset sequences, and a
// randomized sweep against a reference shift model. Expected results go
// into a scoreboard queue when a request is accepted and are popped when
// the unit presents its result.
// ---------------------------------------------------------------------------
module tb_shifter_iterative;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ctl0;
    logic        ctl1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int fails  = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c0;
        logic        c1;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    shifter_iterative dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctl0      (ctl0),
        .ctl1      (ctl1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the bench can never hang
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", checks, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference shift: right logical/arithmetic, left always zero-fill
    function automatic logic [31:0] refShift(input logic [31:0] av, input logic [31:0] bv,
                                             input logic c0, input logic c1);
        logic [4:0] sh;
        sh = bv[4:0];
        if (c1) begin
            if (c0) return av >> sh;
            else    return 32'($signed(av) >>> sh);
        end
        return av << sh;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Issue one request (called at a negedge), push its expected result, and
    // measure the accept-to-out_valid latency. Returns at a negedge with
    // out_valid expected high.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input logic c0, input logic c1, input logic [31:0] expv);
        int waitCnt;
        int lat;
        waitCnt = 0;
        while (!in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        check("in_ready before request", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        ctl0      = c0;
        ctl1      = c1;
        @(posedge clk);
        exp_q.push_back(expv);
        @(negedge clk);
        // Scramble inputs after the accept edge; they must not matter now
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        ctl0     = 1'($urandom_range(0, 1));
        ctl1     = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'd5);
    endtask

    // Compare the presented result, optionally stall, then handshake.
    // Called and returns at a negedge.
    task automatic checkOutput(input int stall);
        logic [31:0] expv;
        logic [31:0] held;
        check("out_valid present", {31'd0, out_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard: empty queue, got %h, expected an entry", out_data);
            return;
        end
        expv = exp_q.pop_front();
        check("out_data", out_data, expv);
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall out_valid", {31'd0, out_valid}, 32'd1);
            check("stall out_data", out_data, held);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post-handshake out_valid", {31'd0, out_valid}, 32'd0);
        check("post-handshake in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc0;
        logic        rc1;

        vecs[0] = '{32'h80000000, 32'd4,        1'b1, 1'b1, 32'h08000000};
        vecs[1] = '{32'h80000000, 32'd31,       1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[2] = '{32'h7FFFFFF0, 32'd4,        1'b0, 1'b1, 32'h07FFFFFF};
        vecs[3] = '{32'h00000001, 32'hFFFFFFE5, 1'b1, 1'b0, 32'h00000020};
        vecs[4] = '{32'h80000001, 32'd1,        1'b0, 1'b0, 32'h00000002};
        vecs[5] = '{32'hF0000000, 32'd0,        1'b0, 1'b0, 32'hF0000000};
        vecs[6] = '{32'hDEADBEEF, 32'd31,       1'b1, 1'b1, 32'h00000001};
        vecs[7] = '{32'h00000001, 32'd31,       1'b0, 1'b0, 32'h80000000};
        vecs[8] = '{32'h40000000, 32'd30,       1'b0, 1'b1, 32'h00000001};
        vecs[9] = '{32'hC0000000, 32'h00000023, 1'b0, 1'b1, 32'hF8000000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ctl0      = 1'b0;
        ctl1      = 1'b0;

        // Reset state
        #12;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after reset in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c0, vecs[i].c1, vecs[i].exp);
            checkOutput(0);
        end

        // Backpressure with a competing request while DONE is held
        applyStimulus(32'h12345678, 32'd0, 1'b1, 1'b1, 32'h12345678);
        check("bp out_data", out_data, 32'h12345678);
        in_valid = 1'b1;
        a        = 32'hFFFFFFFF;
        b        = 32'd1;
        ctl0     = 1'b1;
        ctl1     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold out_data", out_data, 32'h12345678);
            check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
            check("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        checkOutput(0);
        // The competing request must not have been queued
        repeat (8) @(negedge clk);
        check("bp no second result", {31'd0, out_valid}, 32'd0);
        check("bp still idle", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of an iteration
        in_valid = 1'b1;
        a        = 32'hA5A5A5A5;
        b        = 32'd7;
        ctl0     = 1'b0;
        ctl1     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset out_data", out_data, 32'd0);
        check("midreset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postreset in_ready", {31'd0, in_ready}, 32'd1);
        check("postreset out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        applyStimulus(32'h0000000F, 32'd2, 1'b1, 1'b1, 32'h00000003);
        checkOutput(0);

        // Randomized sweep against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rc0 = 1'($urandom_range(0, 1));
            rc1 = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc0, rc1, refShift(ra, rb, rc0, rc1));
            checkOutput(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_shifter_iterative

// File: doc/shifter_iterative.md
# shifter_iterative

Multi-cycle, handshaked 32-bit shift unit: accepts an operand, a shift amount and the two shift controls, then produces the shifted result after a fixed five-cycle iteration, one power-of-two stage per cycle. It sits beside the combinational ALU shifter as the area-lean, registered alternative on the datapath. It uses the same control encoding and the same result semantics, with two differences: it adds valid/ready handshakes on both sides, and left shifts always zero-fill.

## Interface
- `WIDTH`, 32, operand/result width (power of two)
- `SHAMT_W`, $clog2(WIDTH) = 5, number of shift-amount bits used and number of iteration cycles
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — reset, asynchronous assert, active-low
- `in_valid` input 1 — request present
- `in_ready` output 1 — unit can accept a request
- `a` input WIDTH — operand to shift
- `b` input WIDTH — shift amount; only `b[SHAMT_W-1:0]` used, upper bits ignored
- `ctl0` input 1 — 1 = logical, 0 = arithmetic
- `ctl1` input 1 — 1 = right shift, 0 = left shift
- `out_valid` output 1 — result present
- `out_ready` input 1 — consumer accepts result
- `out_data` output WIDTH — shifted result

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready` at an edge:
  - data reg ← `a` if `ctl1`=1, else bit-reversed `a`;
  - latch `b[SHAMT_W-1:0]`, `ctl0`, `ctl1`;
  - fill bit ← 0 if `ctl0`=1 or `ctl1`=0, else `a[WIDTH-1]`;
  - stage counter ← 0; go to SHIFT.
- SHIFT: each edge applies stage k (k = 0..SHAMT_W-1). If latched `b[k]`=1, data reg ← data reg shifted right by 2^k, vacated MSBs filled with the fill bit; otherwise data is unchanged. The counter increments. After stage SHAMT_W-1, go to DONE.
- DONE: `out_valid`=1.
  - `out_data` = data reg if latched `ctl1`=1, else bit-reversed data reg. This is a combinational flip on the registered value.
  - On `out_valid & out_ready` at an edge, go to IDLE.
- `in_valid` outside IDLE is ignored; no request is queued and none is dropped silently, because `in_ready`=0.
- Inputs `a`, `b`, `ctl0`, `ctl1` are sampled only at the accept edge; changes afterwards have no effect.
- Shift amount 0 → result equals `a`. Amount WIDTH-1 → at most one original bit survives.
- Arithmetic left is identical to logical left (zero-fill).

## Timing
- Reset (async, any state, including mid-SHIFT or DONE):
  - state ← IDLE; data reg, counter and latched controls ← 0;
  - `out_valid`=0, `out_data`=0, `in_ready`=1 while `rst_n` is low and after release.
- Fixed latency: accept at edge E → `out_valid` rises after edge E+5, independent of `b`.
- `out_data` and `out_valid` stay stable while `out_valid & !out_ready`, for an unbounded hold.
- Result handshake at edge D → `in_ready`=1 after D; the next accept is at D+1 at the earliest. There is no same-edge bypass.
- Minimum initiation interval is 7 cycles with `out_ready` held at 1.
- No combinational path from inputs to outputs except state-decoded `in_ready` and `out_valid`.

## Structure
- Shared package `shifter_pkg`:
  - state enum (IDLE, SHIFT, DONE);
  - `WIDTH` and `SHAMT_W` defaults;
  - control-bit encodings `CTL0_LOGICAL`=1 and `CTL1_RIGHT`=1, shared with the combinational shifter.
- Sub-module `bit_reverse` (parameterized WIDTH, purely combinational) is instantiated twice: input flip and output flip.
- Remaining logic (FSM, counter, stage shift with variable 2^k amount) lives in `shifter_iterative`, roughly 150–250 lines.

## Test plan
- Logical right: a=0x80000000, b=4, ctl0=1, ctl1=1 → out_data=0x08000000, `out_valid` exactly 5 cycles after accept.
- Arithmetic right: a=0x80000000, b=31, ctl0=0, ctl1=1 → 0xFFFFFFFF. Then a=0x7FFFFFF0, b=4 → 0x07FFFFFF.
- Left shifts with upper b bits:
  - a=0x00000001, b=0xFFFFFFE5 (low bits = 5), ctl1=0 → 0x00000020;
  - a=0x80000001, b=1, ctl0=0, ctl1=0 → 0x00000002.
- Backpressure: a=0x12345678, b=0 → 0x12345678. Hold `out_ready`=0 for 10 cycles and drive a second `in_valid` with a=0xFFFFFFFF → `out_data` stable, `in_ready`=0, second request not taken. Release → handshake, `in_ready`=1 next cycle.
- Reset mid-operation: drop `rst_n` 3 cycles after accept → immediately `out_valid`=0, `out_data`=0, `in_ready`=1. After release, a new request a=0x0000000F, b=2, logical right → 0x00000003.
- Randomized sweep (1000 ops, random a/b/ctl, random `out_ready` stalls) checked against a reference model: right shift logical/arithmetic, left zero-fill.
